// File: rtl/digit_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: digit width, FSM states
// and the digit count helper.
package digit_serial_subtractor_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/digit_serial_subtractor_cla_slice4.sv
// Combinational 4-bit carry-lookahead adder slice: s = x + y + cin.
module cla_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is flattened from g/p/cin so no carry waits on a lower one.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Serial a - b, one 4-bit digit per clock LSD first, borrow rippled through a
// carry register. Handshake: a transfer happens on a rising edge where valid && ready.
module digit_serial_subtractor
    import digit_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int N     = digit_count(WIDTH);
    localparam int IDX_W = $clog2(N);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_next;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               borrow_q, ovf_q, zero_q;
    logic [DIGIT_W-1:0] s;
    logic               cout;
    logic               last;

    cla_slice4 u_slice (
        .x    (a_q[idx_q*DIGIT_W +: DIGIT_W]),
        .y    (~b_q[idx_q*DIGIT_W +: DIGIT_W]),
        .cin  (carry_q),
        .s    (s),
        .cout (cout)
    );

    assign last = (idx_q == IDX_W'(N - 1));

    always_comb begin
        diff_next = diff_q;
        diff_next[idx_q*DIGIT_W +: DIGIT_W] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last)     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            carry_q <= 1'b1;
        end else if (state_q == RUN) begin
            diff_q  <= diff_next;
            carry_q <= cout;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                // Flags use diff_next so the final digit is included.
                borrow_q <= ~cout;
                ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
                zero_q   <= (diff_next == '0);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench for digit_serial_subtractor (WIDTH=16) against an
// arithmetic reference model.
module tb_digit_serial_subtractor;

    localparam int W = 16;
    localparam int R = W + 3;  // {borrow, ovf, zero, diff}

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow, ovf, zero;
    logic [1:0]   state_dbg;

    int errors = 0;
    int checks = 0;
    logic [R-1:0] exp_q[$];

    digit_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [R-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        int         sd;
        logic       o;
        t  = {1'b0, x} - {1'b0, y};
        sd = int'($signed(x)) - int'($signed(y));
        o  = (sd > 32767) || (sd < -32768);
        return {t[W], o, (t[W-1:0] == '0), t[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept operands, wait for the result, hold it for `hold` cycles, then transfer.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold,
                          input bit pulse);
        int n;
        logic [R-1:0] e;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(x, y));
        a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("latency", n, 32'd4);
        e = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check("result", {13'd0, borrow, ovf, zero, diff}, {13'd0, e});
            check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
            check("out_valid_in_done", {31'd0, out_valid}, 32'd1);
            if (i < hold) begin
                if (pulse) begin
                    in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
                end
                step();
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
        check("result_held_after_xfer", {13'd0, borrow, ovf, zero, diff}, {13'd0, e});
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {13'd0, borrow, ovf, zero, diff}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases
        run_op(16'h1234, 16'h0234, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 0, 1'b0);
        run_op(16'hABCD, 16'hABCD, 0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1, 1'b0);

        // Backpressure: 5 held cycles with ignored in_valid pulses
        run_op(16'h4321, 16'h1234, 5, 1'b1);
        step();
        check("pulse_ignored_out_valid", {31'd0, out_valid}, 32'd0);
        check("pulse_ignored_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-operation after two digits
        a = 16'h1235; b = 16'h0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid_state_run", {30'd0, state_dbg}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_outputs", {13'd0, borrow, ovf, zero, diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(16'h0005, 16'h0007, 0, 1'b0);

        // Randomized operands with random backpressure
        for (int k = 0; k < 25; k++) begin
            run_op(W'($urandom), W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
